// File: rtl/arb_pkg.sv
// Shared types and mode encodings for the registered round-robin / fixed-priority arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_priority_arbiter_if #(
  parameter int unsigned NUM_REQ = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic               mode_rr;
  logic [NUM_REQ-1:0] req;
  logic               grant_valid;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0]   grant_idx;

  modport master (
    output mode_rr,
    output req,
    input  grant_valid,
    input  grant_onehot,
    input  grant_idx
  );

  modport slave (
    input  mode_rr,
    input  req,
    output grant_valid,
    output grant_onehot,
    output grant_idx
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection: highest set bit (fixed) or first set bit at/after ptr (rr).
module arb_pick
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] e,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mode,
  output logic               found,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   hi_idx;
  logic [IDX_W-1:0]   lo_idx;
  logic [IDX_W:0]     sum;

  always_comb begin
    // Rotating right by ptr puts bit ptr at position 0, so lowest set bit is the rr winner.
    rot = NUM_REQ'({e, e} >> ptr);

    hi_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (e[i]) hi_idx = IDX_W'(i);
    end

    lo_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) lo_idx = IDX_W'(i);
    end

    sum = {1'b0, lo_idx} + {1'b0, ptr};
    if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);

    found  = |e;
    idx    = '0;
    onehot = '0;
    if (found) begin
      idx    = (mode == ARB_MODE_RR) ? sum[IDX_W-1:0] : hi_idx;
      onehot = NUM_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with lock-until-release grants and an optional hold timeout.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_priority_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HoldLast = (MAX_HOLD == 0) ? '1 : HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  IdxMax   = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] onehot_q, onehot_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               holding;
  logic               expiry;
  logic               take_pick;
  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  assign holding = bus.req[idx_q];
  assign expiry  = (MAX_HOLD != 0) && (hold_q == HoldLast);

  // On expiry the holder is excluded so contenders win; on release it is already out of req.
  assign eligible = (state_q == ARB_GRANT && holding && expiry) ? (bus.req & ~onehot_q)
                                                                : bus.req;

  arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .e      (eligible),
    .ptr    (ptr_q),
    .mode   (bus.mode_rr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    onehot_d  = onehot_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    take_pick = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) take_pick = 1'b1;
      end
      ARB_GRANT: begin
        if (!holding) begin
          if (pick_found) begin
            take_pick = 1'b1;
          end else begin
            state_d  = ARB_IDLE;
            valid_d  = 1'b0;
            onehot_d = '0;
            idx_d    = '0;
          end
        end else if (expiry) begin
          if (pick_found) take_pick = 1'b1;
          else            hold_d    = '0;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: ;
    endcase

    if (take_pick) begin
      state_d  = ARB_GRANT;
      valid_d  = 1'b1;
      onehot_d = pick_onehot;
      idx_d    = pick_idx;
      hold_d   = '0;
      ptr_d    = (pick_idx == IdxMax) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      valid_q  <= 1'b0;
      onehot_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.grant_valid  = valid_q;
  assign bus.grant_onehot = onehot_q;
  assign bus.grant_idx    = idx_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: directed scenarios plus random traffic against a queue-free model.
module tb_rr_priority_arbiter;

  logic       clk;
  logic       rst_r;
  logic       mode_r;
  logic [7:0] req_r;

  int n_tests = 0;
  int n_fail  = 0;

  rr_priority_arbiter_if #(.NUM_REQ(8)) bus4 ();
  rr_priority_arbiter_if #(.NUM_REQ(8)) bus0 ();

  assign bus4.req     = req_r;
  assign bus4.mode_rr = mode_r;
  assign bus0.req     = req_r;
  assign bus0.mode_rr = mode_r;

  rr_priority_arbiter #(.NUM_REQ(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (rst_r),
    .bus   (bus4)
  );

  rr_priority_arbiter #(.NUM_REQ(8), .MAX_HOLD(0)) dut0 (
    .clk   (clk),
    .reset (rst_r),
    .bus   (bus0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit valid;
    int idx;
    int ptr;
    int cnt;
  } mdl_t;

  mdl_t m4 = '{0, 0, 0, 0};
  mdl_t m0 = '{0, 0, 0, 0};

  function automatic int pick(bit [7:0] e, int ptr, bit rr);
    if (!rr) begin
      for (int i = 7; i >= 0; i--) if (e[i]) return i;
    end else begin
      for (int k = 0; k < 8; k++) if (e[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  function automatic mdl_t grant_to(mdl_t s, int w);
    mdl_t n = s;
    n.valid = 1'b1;
    n.idx   = w;
    n.cnt   = 0;
    n.ptr   = (w + 1) % 8;
    return n;
  endfunction

  function automatic mdl_t step(mdl_t s, bit [7:0] r, bit rr, bit rst, int maxh);
    mdl_t    n = s;
    bit [7:0] others;
    if (rst) begin
      n = '{0, 0, 0, 0};
    end else if (!s.valid) begin
      if (r != 0) n = grant_to(s, pick(r, s.ptr, rr));
    end else if (!r[s.idx]) begin
      if (r != 0) n = grant_to(s, pick(r, s.ptr, rr));
      else        n = '{0, 0, s.ptr, 0};
    end else if (maxh != 0 && s.cnt == maxh - 1) begin
      others = r & ~(8'd1 << s.idx);
      if (others != 0) n = grant_to(s, pick(others, s.ptr, rr));
      else             n.cnt = 0;
    end else begin
      n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model advances on the same edge the DUTs sample their inputs.
  initial begin
    forever begin
      @(posedge clk);
      m4 = step(m4, req_r, mode_r, rst_r, 4);
      m0 = step(m0, req_r, mode_r, rst_r, 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("m4_valid",  32'(bus4.grant_valid),  32'(m4.valid));
      check("m4_idx",    32'(bus4.grant_idx),    m4.valid ? m4.idx : 0);
      check("m4_onehot", 32'(bus4.grant_onehot), m4.valid ? (1 << m4.idx) : 0);
      check("m0_valid",  32'(bus0.grant_valid),  32'(m0.valid));
      check("m0_idx",    32'(bus0.grant_idx),    m0.valid ? m0.idx : 0);
      check("m0_onehot", 32'(bus0.grant_onehot), m0.valid ? (1 << m0.idx) : 0);
    end
  end

  initial begin
    rst_r  = 1'b1;
    mode_r = 1'b0;
    req_r  = 8'hFF;

    // Reset with all requesting, then fixed priority picks 7.
    tick(); tick();
    check("rst_valid",  32'(bus4.grant_valid),  0);
    check("rst_onehot", 32'(bus4.grant_onehot), 0);
    check("rst_idx",    32'(bus4.grant_idx),    0);
    rst_r = 1'b0;
    tick();
    check("t1_idx",    32'(bus4.grant_idx),    7);
    check("t1_onehot", 32'(bus4.grant_onehot), 32'h80);
    check("t1_valid",  32'(bus4.grant_valid),  1);

    // Fixed priority, release hands over without a bubble, then idle.
    rst_r = 1'b1; tick();
    rst_r = 1'b0; req_r = 8'b0010_0100; tick();
    check("t2_idx5", 32'(bus4.grant_idx), 5);
    req_r = 8'b0000_0100; tick();
    check("t2_idx2",   32'(bus4.grant_idx),   2);
    check("t2_valid2", 32'(bus4.grant_valid), 1);
    req_r = 8'h00; tick();
    check("t2_valid0", 32'(bus4.grant_valid), 0);
    check("t2_idx0",   32'(bus4.grant_idx),   0);

    // Round-robin, all requesting: each line holds exactly four cycles.
    rst_r = 1'b1; mode_r = 1'b1; req_r = 8'hFF; tick();
    rst_r = 1'b0; tick();
    for (int c = 0; c < 36; c++) begin
      check("t3_idx",   32'(bus4.grant_idx),   (c / 4) % 8);
      check("t3_valid", 32'(bus4.grant_valid), 1);
      tick();
    end

    // Lone requester keeps the grant; hold counter restarts every four cycles.
    rst_r = 1'b1; req_r = 8'h08; tick();
    rst_r = 1'b0; tick();
    for (int c = 0; c < 12; c++) begin
      check("t4_idx",   32'(bus4.grant_idx),   3);
      check("t4_valid", 32'(bus4.grant_valid), 1);
      check("t4_hold",  32'(dut.hold_q),       c % 4);
      tick();
    end

    // Reset mid-grant drops the grant and restarts the rr pointer.
    rst_r = 1'b1; req_r = 8'h04; tick();
    rst_r = 1'b0; tick();
    check("t5_pre", 32'(bus4.grant_idx), 2);
    tick();
    rst_r = 1'b1; tick();
    check("t5_rst_valid", 32'(bus4.grant_valid), 0);
    check("t5_rst_idx",   32'(bus4.grant_idx),   0);
    rst_r = 1'b0; req_r = 8'h0C; tick();
    check("t5_idx", 32'(bus4.grant_idx), 2);

    // Unlimited hold: release and new request in one cycle, then long hold.
    rst_r = 1'b1; mode_r = 1'b0; req_r = 8'h02; tick();
    rst_r = 1'b0; tick();
    check("t6_idx1", 32'(bus0.grant_idx), 1);
    req_r = 8'h40; tick();
    check("t6_idx6", 32'(bus0.grant_idx), 6);
    req_r = 8'hFF;
    for (int c = 0; c < 110; c++) begin
      tick();
      check("t6_hold", 32'(bus0.grant_idx), 6);
    end

    // Random traffic, mode flips and occasional resets, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req_r = 8'($urandom);
      else if ($urandom_range(2) == 0) req_r = req_r ^ (8'd1 << $urandom_range(7));
      if ($urandom_range(49) == 0) mode_r = ~mode_r;
      rst_r = ($urandom_range(149) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
